// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, the long-latency allocation
// notice, the register-file write port and the pending-write scoreboard.
//   master : requester/allocator/register-file side (drives requests, alloc)
//   slave  : arbiter side (drives readies, write port, busy_mask)
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REGNUM_W = 5
);
  logic                req0_valid;
  logic [REGNUM_W-1:0] req0_num;
  logic [DATA_W-1:0]   req0_data;
  logic                req0_ready;

  logic                req1_valid;
  logic [REGNUM_W-1:0] req1_num;
  logic [DATA_W-1:0]   req1_data;
  logic                req1_ready;

  logic                alloc_valid;
  logic [REGNUM_W-1:0] alloc_num;

  logic                wr_en;
  logic [REGNUM_W-1:0] wr_num;
  logic [DATA_W-1:0]   wr_data;
  logic [31:0]         busy_mask;

  modport master (
    output req0_valid, req0_num, req0_data,
    output req1_valid, req1_num, req1_data,
    output alloc_valid, alloc_num,
    input  req0_ready, req1_ready,
    input  wr_en, wr_num, wr_data, busy_mask
  );

  modport slave (
    input  req0_valid, req0_num, req0_data,
    input  req1_valid, req1_num, req1_data,
    input  alloc_valid, alloc_num,
    output req0_ready, req1_ready,
    output wr_en, wr_num, wr_data, busy_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. The pipeline (req0) normally owns the single
// write port; the long-latency unit (req1) gets it when req0 is idle or after
// it has been blocked STARVE_MAX consecutive cycles. Grants are registered into
// a one-cycle-latency write port. busy_mask tracks registers with an
// outstanding long-latency write (set on alloc, cleared on req1 writeback).
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : regfile_wb_arbiter_if.slave (requests, readies, write port, busy_mask)
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REGNUM_W   = 5,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned BUSY_W = 32;

  logic [CNT_W-1:0]  starveCnt;
  logic              grant0;
  logic              grant1;
  logic              starved;
  logic [BUSY_W-1:0] setMask;
  logic [BUSY_W-1:0] clrMask;
  logic [BUSY_W-1:0] busyNext;

  // Grant selection; a grant implies valid, so grant == handshake.
  always_comb begin
    starved = (starveCnt == CNT_W'(STARVE_MAX));
    grant1  = !reset && bus.req1_valid && (!bus.req0_valid || starved);
    grant0  = !reset && bus.req0_valid && !grant1;
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Scoreboard update: set is applied after clear so a same-index
  // allocation survives the retiring writeback; r0 is never busy.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (bus.alloc_valid && (bus.alloc_num != '0)) begin
      setMask = BUSY_W'(1) << bus.alloc_num;
    end
    if (grant1) begin
      clrMask = BUSY_W'(1) << bus.req1_num;
    end
    busyNext = ((bus.busy_mask & ~clrMask) | setMask) & ~BUSY_W'(1);
  end

  // Write port, scoreboard and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.wr_en     <= 1'b0;
      bus.wr_num    <= '0;
      bus.wr_data   <= '0;
      bus.busy_mask <= '0;
      starveCnt     <= '0;
    end else begin
      // Writes to r0 are accepted but suppressed at the port.
      bus.wr_en <= (grant0 && (bus.req0_num != '0)) ||
                   (grant1 && (bus.req1_num != '0));
      if (grant0) begin
        bus.wr_num  <= bus.req0_num;
        bus.wr_data <= bus.req0_data;
      end else if (grant1) begin
        bus.wr_num  <= bus.req1_num;
        bus.wr_data <= bus.req1_data;
      end
      bus.busy_mask <= busyNext;
      if (bus.req1_valid && !grant1) begin
        starveCnt <= starved ? starveCnt : starveCnt + CNT_W'(1);
      end else begin
        starveCnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios, a reference
// grant/scoreboard model, and a queue of expected write-port results.
module tb_regfile_wb_arbiter;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REGNUM_W   = 5;
  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .REGNUM_W(REGNUM_W)) bus ();

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .REGNUM_W(REGNUM_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic                en;
    logic [REGNUM_W-1:0] num;
    logic [DATA_W-1:0]   data;
  } wr_t;

  wr_t         sbQ[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] busyModel;
  int          starveModel;
  logic        lastReady1;
  logic [9:0]  pattern;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.req0_valid  = 1'b0; bus.req0_num = '0; bus.req0_data = '0;
    bus.req1_valid  = 1'b0; bus.req1_num = '0; bus.req1_data = '0;
    bus.alloc_valid = 1'b0; bus.alloc_num = '0;
  endtask

  // One clock: check readies against the model, queue the expected write,
  // then check the write port and busy_mask after the edge.
  task automatic cycle();
    logic g0, g1;
    wr_t  e, o;
    #1;
    g1 = !reset && bus.req1_valid &&
         (!bus.req0_valid || (starveModel == int'(STARVE_MAX)));
    g0 = !reset && bus.req0_valid && !g1;
    chk("req0_ready", 64'(bus.req0_ready), 64'(g0));
    chk("req1_ready", 64'(bus.req1_ready), 64'(g1));
    lastReady1 = bus.req1_ready;

    e.en   = !reset && ((g0 && bus.req0_num != 0) || (g1 && bus.req1_num != 0));
    e.num  = g0 ? bus.req0_num  : bus.req1_num;
    e.data = g0 ? bus.req0_data : bus.req1_data;
    sbQ.push_back(e);

    if (reset) begin
      busyModel   = '0;
      starveModel = 0;
    end else begin
      if (g1) busyModel[bus.req1_num] = 1'b0;
      if (bus.alloc_valid && bus.alloc_num != 0) busyModel[bus.alloc_num] = 1'b1;
      busyModel[0] = 1'b0;
      if (bus.req1_valid && !g1)
        starveModel = (starveModel < int'(STARVE_MAX)) ? starveModel + 1 : starveModel;
      else
        starveModel = 0;
    end

    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      chk("sb_underflow", 64'(1), 64'(0));
    end else begin
      o = sbQ.pop_front();
      chk("wr_en", 64'(bus.wr_en), 64'(o.en));
      if (o.en) begin
        chk("wr_num",  64'(bus.wr_num),  64'(o.num));
        chk("wr_data", 64'(bus.wr_data), 64'(o.data));
      end
    end
    chk("busy_mask", 64'(bus.busy_mask), 64'(busyModel));
    @(negedge clk);
  endtask

  initial begin
    busyModel   = '0;
    starveModel = 0;
    lastReady1  = 1'b0;
    pattern     = '0;
    reset = 1'b1;
    idle();
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_wr_en", 64'(bus.wr_en), 64'(0));
    chk("rst_busy",  64'(bus.busy_mask), 64'(0));
    reset = 1'b0;

    // Scenario 1: single pipeline writeback.
    bus.req0_valid = 1'b1; bus.req0_num = 5'd5; bus.req0_data = 32'hDEADBEEF;
    cycle();
    chk("s1_wr_en",   64'(bus.wr_en),   64'(1));
    chk("s1_wr_num",  64'(bus.wr_num),  64'(5));
    chk("s1_wr_data", 64'(bus.wr_data), 64'(32'hDEADBEEF));
    idle();
    cycle();
    chk("s1_idle_wr_en", 64'(bus.wr_en), 64'(0));

    // Scenario 2: both requesters held valid; req1 wins every 5th cycle.
    bus.req0_valid = 1'b1; bus.req0_num = 5'd3; bus.req0_data = 32'h0000AAAA;
    bus.req1_valid = 1'b1; bus.req1_num = 5'd4; bus.req1_data = 32'h0000BBBB;
    for (int i = 0; i < 10; i++) begin
      cycle();
      pattern[i] = lastReady1;
    end
    chk("s2_grant_pattern", 64'(pattern), 64'(10'b1000010000));
    idle();
    cycle();

    // Scenario 3: allocate r7 and r12, retire r7, then alloc r0 is ignored.
    bus.alloc_valid = 1'b1; bus.alloc_num = 5'd7;
    cycle();
    bus.alloc_num = 5'd12;
    cycle();
    bus.alloc_valid = 1'b0;
    chk("s3_busy7_set", 64'(bus.busy_mask[7]), 64'(1));
    cycle();
    chk("s3_busy7_hold", 64'(bus.busy_mask[7]), 64'(1));
    bus.req1_valid = 1'b1; bus.req1_num = 5'd7; bus.req1_data = 32'h77777777;
    cycle();
    bus.req1_valid = 1'b0;
    chk("s3_busy7_clr", 64'(bus.busy_mask), 64'(32'h0000_1000));
    bus.alloc_valid = 1'b1; bus.alloc_num = 5'd0;
    cycle();
    bus.alloc_valid = 1'b0;
    chk("s3_alloc0", 64'(bus.busy_mask), 64'(32'h0000_1000));

    // Scenario 4: same-index alloc and retire; allocation wins.
    bus.alloc_valid = 1'b1; bus.alloc_num = 5'd9;
    cycle();
    bus.req1_valid = 1'b1; bus.req1_num = 5'd9; bus.req1_data = 32'h99999999;
    cycle();
    idle();
    chk("s4_busy9", 64'(bus.busy_mask[9]), 64'(1));
    chk("s4_wr_num", 64'(bus.wr_num), 64'(9));

    // Scenario 5: write to r0 handshakes but does not write.
    bus.req0_valid = 1'b1; bus.req0_num = 5'd0; bus.req0_data = 32'h55555555;
    cycle();
    idle();
    chk("s5_wr_en", 64'(bus.wr_en), 64'(0));

    // Scenario 6: reset during a req1 handshake with busy bits set.
    bus.alloc_valid = 1'b1; bus.alloc_num = 5'd20;
    cycle();
    idle();
    reset = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_num = 5'd20; bus.req1_data = 32'h20202020;
    cycle();
    reset = 1'b0;
    idle();
    chk("s6_wr_en", 64'(bus.wr_en), 64'(0));
    chk("s6_busy",  64'(bus.busy_mask), 64'(0));

    // First cycle out of reset accepts a handshake.
    bus.req0_valid = 1'b1; bus.req0_num = 5'd6; bus.req0_data = 32'h12345678;
    cycle();
    idle();
    chk("post_rst_wr_en",   64'(bus.wr_en),   64'(1));
    chk("post_rst_wr_data", 64'(bus.wr_data), 64'(32'h12345678));
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter REGNUM_W, default 5, meaning register index width (32 registers).
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning the consecutive-cycle limit that promotes requester 1 when it is blocked.
REQ-004 The block SHALL have port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port req0_valid  input  1  pipeline writeback request.
REQ-007 The block SHALL have port req0_num  input  REGNUM_W  pipeline destination register.
REQ-008 The block SHALL have port req0_data  input  DATA_W  pipeline writeback data.
REQ-009 The block SHALL have port req0_ready  output  1  pipeline request accepted this cycle.
REQ-010 The block SHALL have port req1_valid  input  1  long-latency unit writeback request.
REQ-011 The block SHALL have port req1_num  input  REGNUM_W  long-latency destination register.
REQ-012 The block SHALL have port req1_data  input  DATA_W  long-latency writeback data.
REQ-013 The block SHALL have port req1_ready  output  1  long-latency request accepted this cycle.
REQ-014 The block SHALL have port alloc_valid  input  1  long-latency op issued this cycle.
REQ-015 The block SHALL have port alloc_num  input  REGNUM_W  destination of the issued long-latency op.
REQ-016 The block SHALL have port wr_en  output  1  register-file write enable.
REQ-017 The block SHALL have port wr_num  output  REGNUM_W  register-file write index.
REQ-018 The block SHALL have port wr_data  output  DATA_W  register-file write data.
REQ-019 The block SHALL have port busy_mask  output  32  per-register pending long-latency write.

Function
REQ-020 A handshake SHALL occur on reqN when reqN_valid and reqN_ready are both 1 in the same cycle.
REQ-021 req0_ready and req1_ready SHALL be combinational; at most one SHALL be 1 per cycle.
REQ-022 The grant SHALL default to req0 when req0_valid=1.
REQ-023 The grant SHALL go to req1 when req1_valid=1 and either req0_valid=0 or starve_cnt equals STARVE_MAX.
REQ-024 starve_cnt SHALL increment, saturating at STARVE_MAX, each cycle req1_valid=1 without a req1 handshake.
REQ-025 starve_cnt SHALL clear on a req1 handshake or any cycle with req1_valid=0.
REQ-026 After a handshake, wr_en SHALL be 1 in the next cycle, with wr_num/wr_data holding the granted request's registered values, giving a latency of exactly 1 cycle.
REQ-027 wr_en SHALL be 0 in every cycle following a cycle without a handshake.
REQ-028 A handshake with num=0 SHALL complete normally but SHALL produce wr_en=0.
REQ-029 alloc_valid=1 with alloc_num!=0 SHALL set busy_mask[alloc_num] at the next edge.
REQ-030 A req1 handshake SHALL clear busy_mask[req1_num] at the next edge.
REQ-031 A simultaneous set and clear of the same index SHALL leave the bit set, because the new allocation wins.
REQ-032 busy_mask[0] SHALL always be 0.
REQ-033 A req0 handshake SHALL NOT modify busy_mask.
REQ-034 Requesters SHALL hold valid/num/data stable until handshake; the block SHALL NOT buffer un-granted requests.

Reset
REQ-035 While reset=1 at a rising edge, wr_en, wr_num, wr_data, busy_mask, and starve_cnt SHALL become 0.
REQ-036 While reset=1, req0_ready and req1_ready SHALL be 0.
REQ-037 A handshake in progress when reset asserts SHALL be discarded, producing no write after reset.
REQ-038 The first handshake SHALL be possible in the first cycle with reset=0.

Verification
REQ-039 Scenario 1: req0 only, num=5, data=0xDEADBEEF -> req0_ready=1 the same cycle; next cycle wr_en=1, wr_num=5, wr_data=0xDEADBEEF.
REQ-040 Scenario 2: req0 and req1 both held valid continuously -> req0 granted 4 cycles, req1 granted on the 5th cycle, then the counter restarts.
REQ-041 Scenario 3: alloc num=7, later req1 num=7 handshake -> busy_mask[7] is 1 between those edges and 0 after; alloc num=0 -> busy_mask unchanged.
REQ-042 Scenario 4: alloc num=9 in the same cycle as a req1 handshake on num=9 -> busy_mask[9]=1 afterwards.
REQ-043 Scenario 5: req0 handshake num=0 -> req0_ready=1 and wr_en=0 in the next cycle.
REQ-044 Scenario 6: reset asserted in the cycle of a req1 handshake with busy bits set -> next cycle wr_en=0 and busy_mask=0.
